// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle 16-bit-instruction MIPS-like core with a
// 4-entry register file, BEQ branching and HALT.
// Optional feature: define MIPS_MEM_EN to build the data memory
// (DMEM_DEPTH words) and enable LW/SW. Without it, LW/SW execute as NOP.
module mips_multicycle #(
    parameter int DW         = 16,
    parameter int PCW        = 8,
    parameter int DMEM_DEPTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    output logic [PCW-1:0] imem_addr,
    input  logic [15:0]    imem_data,
    output logic [15:0]    IR,
    output logic [DW-1:0]  WD,
    output logic           instr_done,
    output logic           halted
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

`ifdef MIPS_MEM_EN
    localparam bit MEM_EN = 1'b1;
    localparam int AW     = $clog2(DMEM_DEPTH);
`else
    localparam bit MEM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t state, nxt;

    logic [PCW-1:0] pc;
    logic [DW-1:0]  rf [4];
    logic [DW-1:0]  a, b, alu_out, alu_res;
    logic [DW-1:0]  rs_val, rt_val, wb_data, imm_dw;
    logic [PCW-1:0] imm_pc;
    logic [1:0]     rs, rt, rd, wb_dst;
    logic [3:0]     op;
    logic           is_nop, is_mem, is_rtype;

    assign op     = IR[15:12];
    assign rs     = IR[11:10];
    assign rt     = IR[9:8];
    assign rd     = IR[7:6];
    assign imm_dw = DW'($signed(IR[7:0]));
    // branch offset is applied modulo 2^PCW, so sign-extend/truncate to PCW
    assign imm_pc = PCW'($signed(IR[7:0]));

    assign imem_addr = pc;
    assign halted    = (state == S_HALT);

    // $0 is hardwired to zero on read
    assign rs_val = (rs == 2'd0) ? '0 : rf[rs];
    assign rt_val = (rt == 2'd0) ? '0 : rf[rt];

    assign is_mem   = MEM_EN && ((op == OP_LW) || (op == OP_SW));
    assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                      (op == OP_OR)  || (op == OP_SLT);
    assign wb_dst   = is_rtype ? rd : rt;

    // classify opcodes that do nothing (unknown, or memory ops when memory absent)
    always_comb begin
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
            OP_ADDI, OP_BEQ, OP_HALT: is_nop = 1'b0;
            OP_LW, OP_SW:             is_nop = !MEM_EN;
            default:                  is_nop = 1'b1;
        endcase
    end

    // ALU: register ops, else base+imm (ADDI and memory address)
    always_comb begin
        alu_res = a + imm_dw;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = a + imm_dw;
        endcase
    end

`ifdef MIPS_MEM_EN
    logic [DW-1:0] dmem [DMEM_DEPTH];
    logic [DW-1:0] mdr;
    logic [AW-1:0] maddr;

    assign maddr   = alu_out[AW-1:0];
    assign wb_data = (op == OP_LW) ? mdr : alu_out;

    // data memory store; not cleared by reset, and a store is dropped while reset is high
    always_ff @(posedge clock) begin
        if (!reset && state == S_MEM && op == OP_SW)
            dmem[maddr] <= b;
    end

    // memory data register captures the load in MEM
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mdr <= '0;
        else if (state == S_MEM && op == OP_LW)
            mdr <= dmem[maddr];
    end
`else
    assign wb_data = alu_out;
`endif

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= nxt;
    end

    // next-state logic and the completion pulse in each instruction's final state
    always_comb begin
        nxt        = state;
        instr_done = 1'b0;
        case (state)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (op == OP_HALT) nxt = S_HALT;
                else if (is_nop) begin
                    nxt        = S_FETCH;
                    instr_done = 1'b1;
                end else nxt = S_EXEC;
            end
            S_EXEC: begin
                if (op == OP_BEQ) begin
                    nxt        = S_FETCH;
                    instr_done = 1'b1;
                end else if (is_mem) nxt = S_MEM;
                else                 nxt = S_WB;
            end
            S_MEM: begin
                if (op == OP_LW) nxt = S_WB;
                else begin
                    nxt        = S_FETCH;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                nxt        = S_FETCH;
                instr_done = 1'b1;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end

    // datapath registers: PC, IR, operand latches, ALU result, write-back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            IR      <= '0;
            WD      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    IR <= imem_data;
                    pc <= pc + PCW'(1);
                end
                S_DECODE: begin
                    a <= rs_val;
                    b <= rt_val;
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    // pc already points past the branch
                    if (op == OP_BEQ && a == b) pc <= pc + imm_pc;
                end
                S_WB: begin
                    WD <= wb_data;
                    if (wb_dst != 2'd0) rf[wb_dst] <= wb_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: instruction-level reference model drives checks of
// cycle counts, write-back data and PC flow for directed and random programs.
module tb_mips_multicycle;

`ifdef MIPS_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic        clock, reset;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data, IR;
    logic [15:0] WD;
    logic        instr_done, halted;

    logic [3:0]  imem_addr32;
    logic [15:0] imem_data32, IR32;
    logic [31:0] WD32;
    logic        instr_done32, halted32;

    logic [15:0] prog   [256];
    logic [15:0] prog32 [16];

    int n_cmp = 0;
    int n_err = 0;

    // instruction-level model state
    logic [15:0] m_regs [4];
    logic [15:0] m_dmem [16];
    logic [15:0] m_wd;
    int          m_pc;

    mips_multicycle #(.DW(16), .PCW(8), .DMEM_DEPTH(16)) dut (
        .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .IR(IR), .WD(WD), .instr_done(instr_done), .halted(halted)
    );

    mips_multicycle #(.DW(32), .PCW(4), .DMEM_DEPTH(16)) dut32 (
        .clock(clock), .reset(reset), .imem_addr(imem_addr32), .imem_data(imem_data32),
        .IR(IR32), .WD(WD32), .instr_done(instr_done32), .halted(halted32)
    );

    assign imem_data   = prog[imem_addr];
    assign imem_data32 = prog32[imem_addr32];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] enc_r(input int op, input int rs, input int rt, input int rd);
        logic [3:0] o;
        logic [1:0] s, t, d;
        o = 4'(op); s = 2'(rs); t = 2'(rt); d = 2'(rd);
        return {o, s, t, d, 6'b0};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
        logic [3:0] o;
        logic [1:0] s, t;
        logic [7:0] i;
        o = 4'(op); s = 2'(rs); t = 2'(rt); i = 8'(imm);
        return {o, s, t, i};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h9000;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_pc = 0;
        m_wd = 16'h0;
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
    endtask

    // run one instruction on the model, then on the DUT, and compare
    task automatic step_check(input string tag);
        logic [15:0] ins, a, b, imm, res;
        logic [3:0]  op;
        int rs, rt, rd, dst, exp_cyc, cyc, addr;
        bit wr;
        ins = prog[m_pc];
        op  = ins[15:12];
        rs  = int'(ins[11:10]);
        rt  = int'(ins[9:8]);
        rd  = int'(ins[7:6]);
        imm = {{8{ins[7]}}, ins[7:0]};
        a   = m_regs[rs];
        b   = m_regs[rt];
        m_pc = (m_pc + 1) & 255;
        wr = 1'b0; dst = 0; res = 16'h0; exp_cyc = 2;
        case (op)
            4'h0: begin res = a + b; dst = rd; wr = 1'b1; exp_cyc = 4; end
            4'h1: begin res = a - b; dst = rd; wr = 1'b1; exp_cyc = 4; end
            4'h2: begin res = a & b; dst = rd; wr = 1'b1; exp_cyc = 4; end
            4'h3: begin res = a | b; dst = rd; wr = 1'b1; exp_cyc = 4; end
            4'h7: begin res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; dst = rd; wr = 1'b1; exp_cyc = 4; end
            4'h4: begin res = a + imm; dst = rt; wr = 1'b1; exp_cyc = 4; end
            4'h8: begin
                exp_cyc = 3;
                if (a == b) m_pc = (m_pc + int'($signed(imm))) & 255;
            end
            4'h5: if (MEM_EN) begin
                addr = int'(a + imm) & 15;
                res = m_dmem[addr]; dst = rt; wr = 1'b1; exp_cyc = 5;
            end
            4'h6: if (MEM_EN) begin
                addr = int'(a + imm) & 15;
                m_dmem[addr] = b; exp_cyc = 4;
            end
            default: ;
        endcase
        if (wr) begin
            m_wd = res;
            if (dst != 0) m_regs[dst] = res;
        end
        cyc = 1;
        while (instr_done !== 1'b1 && cyc <= 8) begin
            @(posedge clock); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc !== exp_cyc) begin
            n_err++;
            $display("FAIL %s cycles ins=%h got %0d want %0d", tag, ins, cyc, exp_cyc);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (WD !== m_wd) begin
            n_err++;
            $display("FAIL %s WD ins=%h got %h want %h", tag, ins, WD, m_wd);
        end
        n_cmp++;
        if (imem_addr !== 8'(m_pc)) begin
            n_err++;
            $display("FAIL %s next_pc ins=%h got %0d want %0d", tag, ins, imem_addr, m_pc);
        end
        n_cmp++;
        if (IR !== ins) begin
            n_err++;
            $display("FAIL %s IR got %h want %h", tag, IR, ins);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({imem_addr, IR, WD, instr_done, halted} !== '0) begin
            n_err++;
            $display("FAIL reset_async got pc=%h ir=%h wd=%h done=%b halt=%b want all 0",
                     imem_addr, IR, WD, instr_done, halted);
        end
        n_cmp++;
        if ({imem_addr32, IR32, WD32, instr_done32, halted32} !== '0) begin
            n_err++;
            $display("FAIL reset_async32 got pc=%h ir=%h wd=%h want all 0", imem_addr32, IR32, WD32);
        end
        reset = 1'b0;
    endtask

    task automatic test_arith();
        clear_prog();
        prog[0] = enc_i(4, 0, 1, 5);
        prog[1] = enc_i(4, 0, 2, 3);
        prog[2] = enc_r(0, 1, 2, 3);
        prog[3] = enc_r(1, 2, 1, 3);
        prog[4] = enc_r(7, 2, 1, 3);
        prog[5] = enc_r(2, 1, 3, 2);
        prog[6] = enc_r(3, 1, 2, 0);
        prog[7] = 16'hA000;
        do_reset();
        step_check("addi1");
        step_check("addi2");
        step_check("add");
        n_cmp++;
        if (WD !== 16'd8) begin n_err++; $display("FAIL add_const got %h want 0008", WD); end
        step_check("sub");
        n_cmp++;
        if (WD !== 16'hFFFE) begin n_err++; $display("FAIL sub_const got %h want fffe", WD); end
        step_check("slt");
        n_cmp++;
        if (WD !== 16'd1) begin n_err++; $display("FAIL slt_const got %h want 0001", WD); end
        step_check("and");
        step_check("or_r0");
        step_check("nop");
    endtask

    task automatic test_branch();
        for (int run = 0; run < 2; run++) begin
            clear_prog();
            prog[0] = enc_i(4, 0, 1, 7);
            prog[4] = (run == 0) ? enc_i(8, 1, 1, -2) : enc_i(8, 1, 0, -2);
            do_reset();
            for (int k = 0; k < 5; k++) step_check("branch");
            n_cmp++;
            if (imem_addr !== ((run == 0) ? 8'd3 : 8'd5)) begin
                n_err++;
                $display("FAIL beq_target run=%0d got %0d want %0d", run, imem_addr, (run == 0) ? 3 : 5);
            end
        end
    endtask

    task automatic test_mem();
        clear_prog();
        prog[0] = enc_i(4, 0, 1, 8'h12);
        for (int k = 1; k <= 8; k++) prog[k] = enc_r(0, 1, 1, 1);
        prog[9]  = enc_i(4, 1, 1, 8'h34);
        prog[10] = enc_i(6, 0, 1, 2);
        prog[11] = enc_i(5, 0, 2, 2);
        prog[12] = enc_r(0, 2, 0, 3);
        do_reset();
        for (int k = 0; k < 11; k++) step_check("mem_setup");
        n_cmp++;
        if (WD !== 16'h1234) begin n_err++; $display("FAIL mem_build got %h want 1234", WD); end
        step_check("lw");
        step_check("mem_readback");
        n_cmp++;
        if (WD !== (MEM_EN ? 16'h1234 : 16'h0000)) begin
            n_err++;
            $display("FAIL lw_value got %h want %h", WD, MEM_EN ? 16'h1234 : 16'h0000);
        end
    endtask

    task automatic test_halt();
        clear_prog();
        prog[0] = enc_i(4, 0, 1, 9);
        prog[1] = 16'hF000;
        do_reset();
        step_check("pre_halt");
        n_cmp++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL halted_early got %b want 0", halted); end
        repeat (2) begin @(posedge clock); #1; end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (halted !== 1'b1 || imem_addr !== 8'd2 || instr_done !== 1'b0 ||
                WD !== 16'd9 || IR !== 16'hF000) begin
                n_err++;
                $display("FAIL halt_frozen cyc=%0d got halt=%b pc=%0d done=%b wd=%h ir=%h want 1,2,0,0009,f000",
                         k, halted, imem_addr, instr_done, WD, IR);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid();
        clear_prog();
        prog[0] = enc_i(4, 0, 1, 5);
        prog[1] = enc_i(4, 0, 2, 3);
        prog[2] = enc_r(0, 1, 2, 3);
        do_reset();
        step_check("rm_addi1");
        step_check("rm_addi2");
        repeat (3) begin @(posedge clock); #1; end
        n_cmp++;
        if (instr_done !== 1'b1) begin n_err++; $display("FAIL rm_in_wb got %b want 1", instr_done); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({imem_addr, IR, WD, instr_done, halted} !== '0) begin
            n_err++;
            $display("FAIL reset_mid got pc=%h ir=%h wd=%h done=%b halt=%b want all 0",
                     imem_addr, IR, WD, instr_done, halted);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (WD !== 16'h0 || imem_addr !== 8'h0) begin
            n_err++;
            $display("FAIL reset_hold got wd=%h pc=%h want 0", WD, imem_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        m_pc = 0; m_wd = 16'h0;
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
        step_check("rm_again1");
        step_check("rm_again2");
        step_check("rm_again3");
    endtask

    task automatic test_wide();
        int cyc;
        for (int i = 0; i < 16; i++) prog32[i] = 16'h9000;
        prog32[0] = 16'h41FF;
        do_reset();
        cyc = 1;
        while (instr_done32 !== 1'b1 && cyc <= 8) begin @(posedge clock); #1; cyc++; end
        n_cmp++;
        if (cyc !== 4) begin n_err++; $display("FAIL w32_cycles got %0d want 4", cyc); end
        @(posedge clock); #1;
        n_cmp++;
        if (WD32 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL w32_wd got %h want ffffffff", WD32); end
        for (int k = 1; k <= 15; k++) begin
            cyc = 1;
            while (instr_done32 !== 1'b1 && cyc <= 8) begin @(posedge clock); #1; cyc++; end
            @(posedge clock); #1;
            n_cmp++;
            if (cyc !== 2 || imem_addr32 !== 4'((k + 1) % 16)) begin
                n_err++;
                $display("FAIL w32_pc k=%0d got pc=%0d cyc=%0d want pc=%0d cyc=2",
                         k, imem_addr32, cyc, (k + 1) % 16);
            end
        end
    endtask

    task automatic test_random();
        int op;
        clear_prog();
        // clear the data memory first so later loads have defined contents
        for (int k = 0; k < 16; k++) prog[k] = enc_i(6, 0, 0, k);
        for (int k = 16; k < 256; k++) begin
            op = int'($urandom_range(0, 14));
            prog[k] = {4'(op), 12'($urandom)};
        end
        for (int k = 0; k < 16; k++) m_dmem[k] = 16'h0;
        do_reset();
        for (int k = 0; k < 150; k++) step_check("random");
    endtask

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 16; k++) m_dmem[k] = 16'h0;
        clear_prog();
        for (int i = 0; i < 16; i++) prog32[i] = 16'h9000;
        test_reset();
        test_arith();
        test_branch();
        test_mem();
        test_halt();
        test_reset_mid();
        test_wide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 Parameter DW, default 16: datapath/register width, legal 16..32.
REQ-002 Parameter PCW, default 8: PC width in instruction words.
REQ-003 Parameter DMEM_DEPTH, default 16: data memory words (power of 2).
REQ-004 Port clock  input  1: single clock, all state updates on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high.
REQ-006 Port imem_addr  output  PCW: current PC, word address.
REQ-007 Port imem_data  input  16: instruction word at imem_addr, combinational read.
REQ-008 Port IR  output  16: instruction register.
REQ-009 Port WD  output  DW: last register write-back data.
REQ-010 Port instr_done  output  1: one-cycle pulse in the final state of each instruction.
REQ-011 Port halted  output  1: high once HALT has executed.

Function
REQ-012 Encoding: op[15:12], rs[11:10], rt[9:8], rd[7:6]; imm[7:0] sign-extended to DW.
REQ-013 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0111 SLT (rd<-rs op rt); 0100 ADDI (rt<-rs+imm); 0101 LW; 0110 SW; 1000 BEQ; 1111 HALT; all others NOP.
REQ-014 Register file: 4 x DW; $0 reads zero, writes to $0 discarded, WD still updated.
REQ-015 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: IR<-imem_data, PC<-PC+1 (wraps modulo 2^PCW); next DECODE.
REQ-017 DECODE: read rs/rt into A/B; HALT->HALT state; NOP->FETCH with instr_done; else EXEC.
REQ-018 R-type/ADDI: EXEC->WB; WB writes register and WD; 4 cycles total, instr_done in WB.
REQ-019 BEQ: EXEC compares A==B; if equal PC<-PC+imm (PC already incremented, modulo 2^PCW); 3 cycles, instr_done in EXEC; next FETCH.
REQ-020 LW: EXEC address=A+imm; MEM reads dmem; WB writes rt; 5 cycles.
REQ-021 SW: EXEC address; MEM writes B to dmem; 4 cycles, instr_done in MEM, WD unchanged.
REQ-022 Dmem address = low log2(DMEM_DEPTH) bits of computed address (wraps).
REQ-023 Arithmetic modulo 2^DW, overflow ignored; SLT signed, result 1 or 0.
REQ-024 HALT state: absorbing; halted=1, PC/IR/registers frozen, instr_done 0; left only by reset.

Reset
REQ-025 Reset asserted: state FETCH, PC 0, IR 0, WD 0, registers 0, instr_done 0, halted 0, immediately and independent of clock.
REQ-026 Reset mid-instruction aborts it with no register or dmem write; dmem contents otherwise not cleared.
REQ-027 First fetch on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro MIPS_MEM_EN defined: LW/SW and DMEM_DEPTH-word data memory implemented per REQ-020..022.
REQ-029 MIPS_MEM_EN undefined: no data memory; LW/SW decode as NOP (2 cycles, no state change).

Verification
REQ-030 ADDI $1,$0,5; ADDI $2,$0,3; ADD $3,$1,$2 -> WD 5,3,8 at cycles 4,8,12; instr_done pulses at same cycles.
REQ-031 SUB $3,$2,$1 with $1=5,$2=3 -> WD=0xFFFE (DW=16); SLT $3,$2,$1 -> WD=1.
REQ-032 BEQ $1,$1,-2 at PC 4 -> next imem_addr 3; BEQ not taken -> next PC 5; 3-cycle timing.
REQ-033 MIPS_MEM_EN: SW $1 to addr 2 then LW $2 from addr 2 ($1=0x1234) -> WD=0x1234, LW 5 cycles; macro undefined -> $2 unchanged, 2 cycles.
REQ-034 HALT -> halted=1, imem_addr frozen for 10 cycles; reset asserted mid-ADD WB-1 -> all outputs 0 asynchronously, no register write.
REQ-035 DW=32, PCW=4: ADDI $1,$0,-1 -> WD=0xFFFFFFFF; PC 15 fetch wraps to 0.
